led_fb_write_arbiter: RTL and testbench

- Shares the LED panel frame-buffer write port between two command requesters: req0 (UART command decoder) and req1 (pattern/scroll engine).
- Grants whole commands round-robin and drives a single registered write port into the frame-buffer/refresh block.
- Sequences multi-cycle clear-screen sweeps.
- Handles the RGB colour register update command.

---
 rtl/led_fb_write_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_led_fb_write_arbiter.sv | 541 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_fb_write_arbiter
// Purpose  : Lets two command requesters share the LED panel frame-buffer
//            write port. req0 is the UART command decoder and req1 is the
//            pattern/scroll engine. Whole commands are granted round-robin and
//            drive one registered write port. The arbiter sequences the
//            multi-cycle clear-all sweeps and the RGB colour register loads.
// Options  : LED_FB_FRAME_SYNC_EN - when defined, requests are accepted only
//            while a frame window is open. frame_start opens the window. The
//            first IDLE cycle with no valid requester closes it.
// Revision : 1.0 - initial release
// ============================================================================
module led_fb_write_arbiter #(
  parameter int NUM_COLS = 16,
  parameter int COL_W    = 4,
  parameter int ROW_W    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [COL_W-1:0] req0_col,
  input  logic [ROW_W-1:0] req0_row,
  input  logic [2:0]       req0_rgb,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [COL_W-1:0] req1_col,
  input  logic [ROW_W-1:0] req1_row,
  input  logic [2:0]       req1_rgb,
  input  logic             frame_start,
  output logic             fb_we,
  output logic [COL_W-1:0] fb_col,
  output logic [ROW_W-1:0] fb_row,
  output logic             fb_bit,
  output logic             fb_col_clr,
  output logic             rgb_we,
  output logic [2:0]       rgb_data,
  output logic             grant_id,
  output logic             busy
);

  localparam logic [1:0] OP_SET_PIX = 2'b00;
  localparam logic [1:0] OP_CLR_PIX = 2'b01;
  localparam logic [1:0] OP_CLR_ALL = 2'b10;
  localparam logic [1:0] OP_SET_RGB = 2'b11;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state;
  logic             last_grant;
  logic [COL_W-1:0] sweep_col;
  logic             window_open;

  logic             grant0;
  logic             grant1;
  logic             xfer;
  logic             xfer_id;
  logic [1:0]       sel_op;
  logic [COL_W-1:0] sel_col;
  logic [ROW_W-1:0] sel_row;
  logic [2:0]       sel_rgb;

`ifdef LED_FB_FRAME_SYNC_EN
  // The frame window opens on frame_start and closes once the batch has drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      window_open <= 1'b0;
    end else if (frame_start) begin
      window_open <= 1'b1;
    end else if (state == IDLE && !req0_valid && !req1_valid) begin
      window_open <= 1'b0;
    end
  end
`else
  // Without frame sync the window is always open and frame_start has no effect.
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign window_open        = 1'b1;
`endif

  // Round-robin grant. A contested cycle goes to the requester that was not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && window_open) begin
      if (req0_valid && (!req1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 | grant1;
  assign xfer_id    = grant1;

  // Route the payload of the granted requester to the output stage.
  always_comb begin
    sel_op  = req0_op;
    sel_col = req0_col;
    sel_row = req0_row;
    sel_rgb = req0_rgb;
    if (grant1) begin
      sel_op  = req1_op;
      sel_col = req1_col;
      sel_row = req1_row;
      sel_rgb = req1_rgb;
    end
  end

  // Command FSM and registered write port. Strobes default low and the addresses hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      sweep_col  <= '0;
      fb_we      <= 1'b0;
      fb_col     <= '0;
      fb_row     <= '0;
      fb_bit     <= 1'b0;
      fb_col_clr <= 1'b0;
      rgb_we     <= 1'b0;
      rgb_data   <= 3'b000;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      fb_we      <= 1'b0;
      rgb_we     <= 1'b0;
      fb_col_clr <= 1'b0;
      busy       <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            last_grant <= xfer_id;
            grant_id   <= xfer_id;
            case (sel_op)
              OP_SET_PIX, OP_CLR_PIX: begin
                fb_we  <= 1'b1;
                fb_col <= sel_col;
                fb_row <= sel_row;
                fb_bit <= (sel_op == OP_SET_PIX);
              end
              OP_CLR_ALL: begin
                state      <= SWEEP;
                sweep_col  <= '0;
                fb_col     <= '0;
                fb_col_clr <= 1'b1;
                busy       <= 1'b1;
              end
              OP_SET_RGB: begin
                rgb_we   <= 1'b1;
                rgb_data <= sel_rgb;
              end
              default: begin
                fb_we <= 1'b0;
              end
            endcase
          end
        end
        SWEEP: begin
          // The column on the port now is the last one, so the sweep ends here without wrapping.
          if (sweep_col == LAST_COL) begin
            state <= IDLE;
          end else begin
            sweep_col  <= sweep_col + COL_W'(1);
            fb_col     <= sweep_col + COL_W'(1);
            fb_col_clr <= 1'b1;
            busy       <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_fb_write_arbiter
// Purpose  : Self-checking bench for led_fb_write_arbiter. The reference model
//            queues the per-cycle output effects of each accepted command.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_fb_write_arbiter;

  localparam int NUM_COLS = 16;
  localparam int COL_W    = 4;
  localparam int ROW_W    = 3;

`ifdef LED_FB_FRAME_SYNC_EN
  localparam logic FS_IDLE = 1'b1;
`else
  localparam logic FS_IDLE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req0_valid = 1'b0;
  logic             req0_ready;
  logic [1:0]       req0_op = 2'b00;
  logic [COL_W-1:0] req0_col = '0;
  logic [ROW_W-1:0] req0_row = '0;
  logic [2:0]       req0_rgb = 3'b000;
  logic             req1_valid = 1'b0;
  logic             req1_ready;
  logic [1:0]       req1_op = 2'b00;
  logic [COL_W-1:0] req1_col = '0;
  logic [ROW_W-1:0] req1_row = '0;
  logic [2:0]       req1_rgb = 3'b000;
  logic             frame_start = 1'b0;
  logic             fb_we;
  logic [COL_W-1:0] fb_col;
  logic [ROW_W-1:0] fb_row;
  logic             fb_bit;
  logic             fb_col_clr;
  logic             rgb_we;
  logic [2:0]       rgb_data;
  logic             grant_id;
  logic             busy;

  led_fb_write_arbiter #(
    .NUM_COLS(NUM_COLS),
    .COL_W   (COL_W),
    .ROW_W   (ROW_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_col   (req0_col),
    .req0_row   (req0_row),
    .req0_rgb   (req0_rgb),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_col   (req1_col),
    .req1_row   (req1_row),
    .req1_rgb   (req1_rgb),
    .frame_start(frame_start),
    .fb_we      (fb_we),
    .fb_col     (fb_col),
    .fb_row     (fb_row),
    .fb_bit     (fb_bit),
    .fb_col_clr (fb_col_clr),
    .rgb_we     (rgb_we),
    .rgb_data   (rgb_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] act_out;
  assign act_out = {fb_we, fb_col, fb_row, fb_bit, fb_col_clr, rgb_we, rgb_data, grant_id, busy};

  // Reference model: each accepted command becomes a list of per-cycle output effects.
  typedef struct {
    int               kind;   // 1 pixel write, 2 column clear, 3 rgb load
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             b;
    logic [2:0]       rgb;
  } ent_t;

  ent_t             pend[$];
  logic             m_last;
  logic             m_win;
  logic             c_we, c_bit, c_clr, c_rgbwe, c_gid, c_busy;
  logic [COL_W-1:0] c_col;
  logic [ROW_W-1:0] c_row;
  logic [2:0]       c_rgb;

  function automatic logic [15:0] exp_out();
    return {c_we, c_col, c_row, c_bit, c_clr, c_rgbwe, c_rgb, c_gid, c_busy};
  endfunction

  task automatic model_reset();
    pend.delete();
    m_last  = 1'b1;
    m_win   = 1'b0;
    c_we    = 1'b0;
    c_bit   = 1'b0;
    c_clr   = 1'b0;
    c_rgbwe = 1'b0;
    c_gid   = 1'b0;
    c_busy  = 1'b0;
    c_col   = '0;
    c_row   = '0;
    c_rgb   = 3'b000;
  endtask

  // Returns {ready1, ready0}. The arbiter accepts only while no sweep is shown.
  function automatic logic [1:0] model_ready();
    logic open;
    logic r0, r1;
`ifdef LED_FB_FRAME_SYNC_EN
    open = m_win;
`else
    open = 1'b1;
`endif
    r0 = 1'b0;
    r1 = 1'b0;
    if (open && !c_busy) begin
      if (req0_valid && req1_valid) begin
        r0 = m_last;
        r1 = !m_last;
      end else begin
        r0 = req0_valid;
        r1 = req1_valid;
      end
    end
    return {r1, r0};
  endfunction

  task automatic model_edge(input logic [1:0] hs);
    ent_t       e;
    logic       id;
    logic [1:0] op;
    if (hs != 2'b00) begin
      id    = hs[1];
      op    = id ? req1_op : req0_op;
      e.col = id ? req1_col : req0_col;
      e.row = id ? req1_row : req0_row;
      e.rgb = id ? req1_rgb : req0_rgb;
      e.b   = (op == 2'b00);
      m_last = id;
      c_gid  = id;
      case (op)
        2'b10: begin
          for (int i = 0; i < NUM_COLS; i++) begin
            e.kind = 2;
            e.col  = COL_W'(i);
            pend.push_back(e);
          end
        end
        2'b11: begin
          e.kind = 3;
          pend.push_back(e);
        end
        default: begin
          e.kind = 1;
          pend.push_back(e);
        end
      endcase
    end
`ifdef LED_FB_FRAME_SYNC_EN
    if (frame_start) m_win = 1'b1;
    else if (!c_busy && !req0_valid && !req1_valid) m_win = 1'b0;
`endif
    c_we    = 1'b0;
    c_clr   = 1'b0;
    c_rgbwe = 1'b0;
    c_busy  = 1'b0;
    if (pend.size() > 0) begin
      e = pend.pop_front();
      case (e.kind)
        1: begin c_we = 1'b1; c_col = e.col; c_row = e.row; c_bit = e.b; end
        2: begin c_clr = 1'b1; c_col = e.col; c_busy = 1'b1; end
        default: begin c_rgbwe = 1'b1; c_rgb = e.rgb; end
      endcase
    end
  endtask

  // One clock: the handshake is taken from the model and the DUT is then sampled 1 time unit after the edge.
  task automatic advance();
    logic [1:0] hs;
    hs = model_ready();
    @(posedge clk);
    model_edge(hs);
    #1;
  endtask

  task automatic reset_dut();
    reset_n     = 1'b0;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    frame_start = FS_IDLE;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    advance();
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (act_out !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want %h", act_out, 16'h0000);
    end
    reset_n = 1'b1;
    advance();
    n_vec++;
    if ({act_out, req1_ready, req0_ready} !== {exp_out(), 2'b00}) begin
      n_err++;
      $display("FAIL reset_release: got %h/%b want %h/%b", act_out, {req1_ready, req0_ready}, exp_out(), 2'b00);
    end
  endtask

  task automatic test_single_write();
    reset_dut();
    req0_valid = 1'b1; req0_op = 2'b00; req0_col = 4'd5; req0_row = 3'd3; req0_rgb = 3'd0;
    #1;
    n_vec++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL single_ready: got %b want %b", {req1_ready, req0_ready}, 2'b01);
    end
    advance();
    req0_valid = 1'b0;
    n_vec++;
    if ({fb_we, fb_col, fb_row, fb_bit, grant_id} !== {1'b1, 4'd5, 3'd3, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL single_write: got we=%b col=%0d row=%0d bit=%b gid=%b want 1 5 3 1 0",
               fb_we, fb_col, fb_row, fb_bit, grant_id);
    end
    advance();
    n_vec++;
    if ({fb_we, fb_col} !== {1'b0, 4'd5}) begin
      n_err++;
      $display("FAIL single_strobe_drop: got we=%b col=%0d want we=0 col=5", fb_we, fb_col);
    end
  endtask

  task automatic test_alternate();
    reset_dut();
    req0_valid = 1'b1; req0_op = 2'b01; req0_col = 4'd2; req0_row = 3'd1;
    req1_valid = 1'b1; req1_op = 2'b01; req1_col = 4'd9; req1_row = 3'd6;
    for (int k = 0; k < 4; k++) begin
      logic g;
      g = k[0];
      #1;
      n_vec++;
      if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL alt_ready[%0d]: got %b want %b", k, {req1_ready, req0_ready}, (g ? 2'b10 : 2'b01));
      end
      advance();
      n_vec++;
      if ({fb_we, fb_bit, grant_id, fb_col} !== {1'b1, 1'b0, g, (g ? 4'd9 : 4'd2)}) begin
        n_err++;
        $display("FAIL alt_write[%0d]: got we=%b bit=%b gid=%b col=%0d want 1 0 %b %0d",
                 k, fb_we, fb_bit, grant_id, fb_col, g, (g ? 9 : 2));
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    advance();
  endtask

  task automatic test_sweep();
    reset_dut();
    req1_valid = 1'b1; req1_op = 2'b10; req1_col = 4'd3; req1_row = 3'd2;
    #1;
    n_vec++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL sweep_ready: got %b want %b", {req1_ready, req0_ready}, 2'b10);
    end
    advance();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_col = 4'd11; req0_row = 3'd4;
    for (int i = 0; i < NUM_COLS; i++) begin
      #1;
      n_vec++;
      if ({busy, fb_col_clr, fb_col, req0_ready} !== {1'b1, 1'b1, COL_W'(i), 1'b0}) begin
        n_err++;
        $display("FAIL sweep_col[%0d]: got busy=%b clr=%b col=%0d rdy0=%b want 1 1 %0d 0",
                 i, busy, fb_col_clr, fb_col, req0_ready, i);
      end
      advance();
    end
    n_vec++;
    if ({busy, fb_col_clr, req0_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL sweep_end: got busy=%b clr=%b rdy0=%b want 0 0 1", busy, fb_col_clr, req0_ready);
    end
    advance();
    req0_valid = 1'b0;
    n_vec++;
    if ({fb_we, fb_col, fb_row, grant_id} !== {1'b1, 4'd11, 3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL sweep_waiter: got we=%b col=%0d row=%0d gid=%b want 1 11 4 0",
               fb_we, fb_col, fb_row, grant_id);
    end
    advance();
  endtask

  task automatic test_rgb();
    reset_dut();
    req0_valid = 1'b1; req0_op = 2'b11; req0_rgb = 3'b101;
    advance();
    req0_valid = 1'b0;
    n_vec++;
    if ({rgb_we, rgb_data, fb_we, fb_col_clr} !== {1'b1, 3'd5, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rgb_load: got rgb_we=%b data=%0d fb_we=%b clr=%b want 1 5 0 0",
               rgb_we, rgb_data, fb_we, fb_col_clr);
    end
    advance();
    n_vec++;
    if ({rgb_we, rgb_data} !== {1'b0, 3'd5}) begin
      n_err++;
      $display("FAIL rgb_drop: got rgb_we=%b data=%0d want 0 5", rgb_we, rgb_data);
    end
  endtask

  task automatic test_reset_mid_sweep();
    reset_dut();
    req1_valid = 1'b1; req1_op = 2'b10;
    advance();
    req1_valid = 1'b0;
    repeat (7) advance();
    n_vec++;
    if ({busy, fb_col} !== {1'b1, 4'd7}) begin
      n_err++;
      $display("FAIL midsweep_col: got busy=%b col=%0d want 1 7", busy, fb_col);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (act_out !== 16'h0000) begin
      n_err++;
      $display("FAIL midsweep_async_reset: got %h want %h", act_out, 16'h0000);
    end
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    advance();
    req0_valid = 1'b1; req0_op = 2'b00; req0_col = 4'd1; req0_row = 3'd0;
    req1_valid = 1'b1; req1_op = 2'b00; req1_col = 4'd2; req1_row = 3'd7;
    #1;
    n_vec++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL post_reset_priority: got %b want %b", {req1_ready, req0_ready}, 2'b01);
    end
    advance();
    req0_valid = 1'b0;
    n_vec++;
    if ({fb_we, fb_col, grant_id} !== {1'b1, 4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL post_reset_write0: got we=%b col=%0d gid=%b want 1 1 0", fb_we, fb_col, grant_id);
    end
    advance();
    req1_valid = 1'b0;
    n_vec++;
    if ({fb_we, fb_col, fb_row, grant_id} !== {1'b1, 4'd2, 3'd7, 1'b1}) begin
      n_err++;
      $display("FAIL post_reset_write1: got we=%b col=%0d row=%0d gid=%b want 1 2 7 1",
               fb_we, fb_col, fb_row, grant_id);
    end
    advance();
  endtask

`ifdef LED_FB_FRAME_SYNC_EN
  task automatic test_frame_sync();
    reset_dut();
    frame_start = 1'b0;
    advance();
    req0_valid = 1'b1; req0_op = 2'b00; req0_col = 4'd6; req0_row = 3'd2;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_vec++;
      if (req0_ready !== 1'b0) begin
        n_err++;
        $display("FAIL fs_closed[%0d]: got rdy0=%b want 0", i, req0_ready);
      end
      advance();
    end
    frame_start = 1'b1;
    advance();
    frame_start = 1'b0;
    n_vec++;
    if (req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL fs_open: got rdy0=%b want 1", req0_ready);
    end
    advance();
    req0_valid = 1'b0;
    n_vec++;
    if ({fb_we, fb_col} !== {1'b1, 4'd6}) begin
      n_err++;
      $display("FAIL fs_write: got we=%b col=%0d want 1 6", fb_we, fb_col);
    end
    advance();
    req0_valid = 1'b1; req0_col = 4'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (req0_ready !== 1'b0) begin
        n_err++;
        $display("FAIL fs_reclosed[%0d]: got rdy0=%b want 0", i, req0_ready);
      end
      advance();
    end
    frame_start = 1'b1;
    advance();
    frame_start = 1'b0;
    advance();
    req0_valid = 1'b0;
    n_vec++;
    if ({fb_we, fb_col} !== {1'b1, 4'd7}) begin
      n_err++;
      $display("FAIL fs_second_write: got we=%b col=%0d want 1 7", fb_we, fb_col);
    end
    advance();
    frame_start = FS_IDLE;
    advance();
  endtask
`else
  task automatic test_frame_start_ignored();
    reset_dut();
    frame_start = 1'b1;
    advance();
    frame_start = 1'b0;
    advance();
    req0_valid = 1'b1; req0_op = 2'b00; req0_col = 4'd6; req0_row = 3'd2;
    #1;
    n_vec++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL nofs_ready: got %b want %b", {req1_ready, req0_ready}, 2'b01);
    end
    advance();
    req0_valid = 1'b0;
    n_vec++;
    if ({fb_we, fb_col, fb_row} !== {1'b1, 4'd6, 3'd2}) begin
      n_err++;
      $display("FAIL nofs_write: got we=%b col=%0d row=%0d want 1 6 2", fb_we, fb_col, fb_row);
    end
    advance();
  endtask
`endif

  function automatic logic [1:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return 2'b00;
    if (r < 7) return 2'b01;
    if (r < 9) return 2'b11;
    return 2'b10;
  endfunction

  task automatic test_random();
    logic [1:0] rdy;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0) begin
        req0_valid = 1'b1;
        req0_op    = rand_op();
        req0_col   = COL_W'($urandom_range(0, 15));
        req0_row   = ROW_W'($urandom_range(0, 7));
        req0_rgb   = 3'($urandom_range(0, 7));
      end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin
        req1_valid = 1'b1;
        req1_op    = rand_op();
        req1_col   = COL_W'($urandom_range(0, 15));
        req1_row   = ROW_W'($urandom_range(0, 7));
        req1_rgb   = 3'($urandom_range(0, 7));
      end
      frame_start = ($urandom_range(0, 3) == 0);
      #1;
      rdy = model_ready();
      n_vec++;
      if ({req1_ready, req0_ready} !== rdy) begin
        n_err++;
        $display("FAIL rand_ready[%0d]: got %b want %b", c, {req1_ready, req0_ready}, rdy);
      end
      advance();
      if (rdy[0]) req0_valid = 1'b0;
      if (rdy[1]) req1_valid = 1'b0;
      n_vec++;
      if (act_out !== exp_out()) begin
        n_err++;
        $display("FAIL rand_outputs[%0d]: got %h want %h", c, act_out, exp_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_alternate();
    test_sweep();
    test_rgb();
    test_reset_mid_sweep();
`ifdef LED_FB_FRAME_SYNC_EN
    test_frame_sync();
`else
    test_frame_start_ignored();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
